// File: rtl/dz_matrix_scan_if.sv
// Digit/colour request and matrix pin bundle for the dot-matrix scan controller.
interface dz_matrix_scan_if;
  logic [3:0] num;
  logic [1:0] color;
  logic       auto_color;
  logic       blink;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic       frame_done;

  modport master (
    output num, color, auto_color, blink,
    input  row, colr, colg, frame_done
  );

  modport slave (
    input  num, color, auto_color, blink,
    output row, colr, colg, frame_done
  );
endinterface

// File: rtl/dz_matrix_scan.sv
// 8x8 bicolour digit scan controller with frame-latched inputs and auto colour cycling.
// Optional blink logic is built only when DZ_BLINK_EN is defined.
module dz_matrix_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          ROW_ACTIVE_LOW = 1'b1,
  parameter int unsigned CYCLE_FRAMES   = 64,
  parameter int unsigned BLINK_FRAMES   = 32
) (
  input  logic            clk,
  input  logic            rst,
  dz_matrix_scan_if.slave bus
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [7:0]  RowIdle = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {PhRed = 2'b01, PhGreen = 2'b10, PhYellow = 2'b11} phase_e;

  function automatic logic [7:0] font_row(input logic [3:0] n, input logic [2:0] r);
    logic [63:0] g;
    case (n)
      4'd0:    g = 64'h003C_6666_6666_3C00;
      4'd1:    g = 64'h0018_3818_1818_3C00;
      4'd2:    g = 64'h003C_6606_1C30_7E00;
      4'd3:    g = 64'h003C_660C_0666_3C00;
      4'd4:    g = 64'h000C_1C2C_4C7E_0C0C;
      4'd5:    g = 64'h007E_607C_0606_663C;
      4'd6:    g = 64'h003C_607C_6666_3C00;
      4'd7:    g = 64'h007E_060C_1818_1800;
      4'd8:    g = 64'h003C_663C_6666_3C00;
      4'd9:    g = 64'h003C_6666_3E06_3C00;
      default: g = 64'h0;
    endcase
    // Row 0 lives in the top byte.
    return g[{~r, 3'b000} +: 8];
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    row_idx_q, row_idx_d;
  logic [3:0]    num_q, num_d;
  logic [1:0]    color_q, color_d;
  logic          auto_q, auto_d;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]    row_q, row_d, colr_q, colr_d, colg_q, colg_d;
  logic          frame_done_q, frame_done_d;
  logic          tick, wrap, visible_d;
  logic [1:0]    eff_color;
  logic [7:0]    glyph;

  assign tick = (div_q == DW'(SCAN_DIV - 1));
  assign wrap = tick && (row_idx_q == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      row_idx_q    <= 3'd7;
      num_q        <= 4'd15;
      color_q      <= 2'b00;
      auto_q       <= 1'b0;
      phase_q      <= PhRed;
      cyc_cnt_q    <= '0;
      row_q        <= RowIdle;
      colr_q       <= 8'h00;
      colg_q       <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_idx_q    <= row_idx_d;
      num_q        <= num_d;
      color_q      <= color_d;
      auto_q       <= auto_d;
      phase_q      <= phase_d;
      cyc_cnt_q    <= cyc_cnt_d;
      row_q        <= row_d;
      colr_q       <= colr_d;
      colg_q       <= colg_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: divider, row index, frame-boundary shadows and colour phase.
  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    row_idx_d = tick ? row_idx_q + 3'd1 : row_idx_q;
    num_d     = wrap ? bus.num        : num_q;
    color_d   = wrap ? bus.color      : color_q;
    auto_d    = wrap ? bus.auto_color : auto_q;
    phase_d   = phase_q;
    cyc_cnt_d = cyc_cnt_q;
    if (wrap) begin
      if (!bus.auto_color) begin
        phase_d   = PhRed;
        cyc_cnt_d = '0;
      end else if (auto_q) begin
        // Only frames that ran with auto colour latched count toward a step.
        if (cyc_cnt_q == CW'(CYCLE_FRAMES - 1)) begin
          cyc_cnt_d = '0;
          unique case (phase_q)
            PhRed:   phase_d = PhGreen;
            PhGreen: phase_d = PhYellow;
            default: phase_d = PhRed;
          endcase
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef DZ_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          blink_q, blink_d, hidden_q, hidden_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q     <= 1'b0;
      hidden_q    <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      blink_q     <= blink_d;
      hidden_q    <= hidden_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  always_comb begin
    blink_d     = wrap ? bus.blink : blink_q;
    hidden_d    = hidden_q;
    blink_cnt_d = blink_cnt_q;
    if (wrap) begin
      if (!bus.blink) begin
        hidden_d    = 1'b0;
        blink_cnt_d = '0;
      end else if (blink_q) begin
        if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          hidden_d    = ~hidden_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  assign visible_d = ~hidden_d;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.blink, BLINK_FRAMES[0]};
  assign visible_d    = 1'b1;
`endif

  // Outputs load the incoming row's values on the tick edge, using post-boundary state.
  always_comb begin
    glyph        = font_row(num_d, row_idx_d);
    eff_color    = auto_d ? phase_d : color_d;
    row_d        = row_q;
    colr_d       = colr_q;
    colg_d       = colg_q;
    frame_done_d = wrap;
    if (tick) begin
      row_d  = ROW_ACTIVE_LOW ? ~(8'd1 << row_idx_d) : (8'd1 << row_idx_d);
      colr_d = (eff_color[0] && visible_d) ? glyph : 8'h00;
      colg_d = (eff_color[1] && visible_d) ? glyph : 8'h00;
    end
  end

  assign bus.row        = row_q;
  assign bus.colr       = colr_q;
  assign bus.colg       = colg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_dz_matrix_scan.sv
// Directed bench for dz_matrix_scan with SCAN_DIV=4, CYCLE_FRAMES=2, BLINK_FRAMES=1.
module tb_dz_matrix_scan;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  dz_matrix_scan_if bus ();

  dz_matrix_scan #(
    .SCAN_DIV      (4),
    .ROW_ACTIVE_LOW(1'b1),
    .CYCLE_FRAMES  (2),
    .BLINK_FRAMES  (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance to just after rising edge k counted from reset release.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  // Edge at which frame f, row r is loaded.
  function automatic int e(input int f, input int r);
    return 4 + 32 * f + 4 * r;
  endfunction

  logic [12:0] auto_r = 13'b0_1110_1111_0011; // bit f = red expected in frame f
  logic [12:0] auto_g = 13'b1_0001_0011_1100;
  logic [7:0]  ex_row;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held with arbitrary inputs.
    bus.num = 4'd8; bus.color = 2'b11; bus.auto_color = 1'b1; bus.blink = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", bus.row, 8'hFF);
    check("rst_colr", bus.colr, 8'h00);
    check("rst_colg", bus.colg, 8'h00);
    check("rst_fd", {7'd0, bus.frame_done}, 8'h00);

    // Digit 5 red, then mid-frame change to 4.
    bus.num = 4'd5; bus.color = 2'b01; bus.auto_color = 1'b0; bus.blink = 1'b0;
    start();
    goto(3);
    check("pre_tick_row", bus.row, 8'hFF);
    goto(4);
    check("d5_r0_row", bus.row, 8'hFE);
    check("d5_r0_colr", bus.colr, 8'h00);
    check("d5_r0_fd", {7'd0, bus.frame_done}, 8'h01);
    goto(5);
    check("fd_pulse_end", {7'd0, bus.frame_done}, 8'h00);
    goto(8);
    check("d5_r1_row", bus.row, 8'hFD);
    check("d5_r1_colr", bus.colr, 8'h7E);
    check("d5_r1_colg", bus.colg, 8'h00);
    goto(16);
    check("d5_r3_colr", bus.colr, 8'h7C);
    bus.num = 4'd4;
    goto(20); check("mid_r4", bus.colr, 8'h06);
    goto(24); check("mid_r5", bus.colr, 8'h06);
    goto(28); check("mid_r6", bus.colr, 8'h66);
    goto(32);
    check("mid_r7_row", bus.row, 8'h7F);
    check("mid_r7_colr", bus.colr, 8'h3C);
    goto(e(1, 0)); check("f1_fd", {7'd0, bus.frame_done}, 8'h01);
    goto(e(1, 2)); check("d4_r2_colr", bus.colr, 8'h1C);
    #2;
    rst = 1'b0;
    #1;
    check("async_row", bus.row, 8'hFF);
    check("async_colr", bus.colr, 8'h00);
    check("async_fd", {7'd0, bus.frame_done}, 8'h00);

    // Yellow 8, then blank.
    bus.num = 4'd8; bus.color = 2'b11;
    start();
    goto(e(0, 1));
    check("y8_colr", bus.colr, 8'h3C);
    check("y8_colg", bus.colg, 8'h3C);
    bus.num = 4'd12;
    for (int r = 0; r < 8; r++) begin
      goto(e(1, r));
      ex_row = ~(8'd1 << r);
      check("blank_row", bus.row, ex_row);
      check("blank_col", bus.colr | bus.colg, 8'h00);
    end

    // Auto colour cycling, drop to fixed red, then re-enable from RED.
    bus.num = 4'd8; bus.color = 2'b00; bus.auto_color = 1'b1;
    start();
    for (int f = 0; f < 13; f++) begin
      goto(e(f, 1));
      check("auto_colr", bus.colr, auto_r[f] ? 8'h3C : 8'h00);
      check("auto_colg", bus.colg, auto_g[f] ? 8'h3C : 8'h00);
      if (f == 8) begin
        bus.auto_color = 1'b0; bus.color = 2'b01;
      end else if (f == 9) begin
        bus.auto_color = 1'b1; bus.color = 2'b00;
      end
    end

    // Blink with one-frame half period.
    bus.num = 4'd8; bus.color = 2'b01; bus.auto_color = 1'b0; bus.blink = 1'b1;
    start();
    for (int f = 0; f < 4; f++) begin
      goto(e(f, 0));
      check("blink_fd", {7'd0, bus.frame_done}, 8'h01);
      goto(e(f, 0) + 1);
      check("blink_fd_low", {7'd0, bus.frame_done}, 8'h00);
      goto(e(f, 1));
`ifdef DZ_BLINK_EN
      check("blink_colr", bus.colr, (f % 2 == 1) ? 8'h00 : 8'h3C);
`else
      check("blink_colr", bus.colr, 8'h3C);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
